uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Buffered UART transmitter that consumes the CPU's byte stream and serializes it onto the UART line. The CPU drives `tx_Data` / `tx_DataValid` with single-cycle pulses and has no back-pressure input, so this block absorbs bursts in an internal FIFO. It then emits 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) at a fixed baud divisor. It sits between the CPU top level and the board's TX pin.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal range ≥ 2.
- `FIFO_DEPTH`, default 16: byte entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock. All logic is rising-edge.
- `reset`  in  1: asynchronous, active-high reset.
- `tx_Data`  in  8: byte from the CPU.
- `tx_DataValid`  in  1: one-cycle write strobe for `tx_Data`.
- `o_tx`  out  1: serial line. Idle level is high.
- `busy`  out  1: high while a frame is on the line.
- `fifo_full`  out  1: FIFO holds `FIFO_DEPTH` entries.
- `fifo_count`  out  log2(FIFO_DEPTH)+1: current occupancy.
- `overflow`  out  1: sticky flag, set when a write is dropped.

## Operation
- Reset values: `o_tx`=1, `busy`=0, `fifo_full`=0, `fifo_count`=0, `overflow`=0, FSM=IDLE, baud counter=0, bit index=0.
- Write acceptance: a write is accepted when `tx_DataValid`=1 and either the FIFO is not full or a pop occurs in the same cycle.
  - Write to a full FIFO without a same-cycle pop: the byte is dropped and `overflow` is set.
  - `overflow` is cleared only by `reset`.
- Pop: allowed only when the registered count is > 0. There is no write-to-pop bypass.
- FSM states:
  - IDLE: `o_tx`=1, `busy`=0. If the FIFO is not empty: pop into the shift register, clear the baud counter, go to START.
  - START: `o_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `o_tx`=shift[bit index] for `CLKS_PER_BIT` cycles per bit. After bit 7, go to STOP.
  - STOP: `o_tx`=1 for `CLKS_PER_BIT` cycles. At the last stop cycle:
    - FIFO not empty: pop and go directly to START, with no idle gap.
    - FIFO empty: go to IDLE.
- `busy`=1 in START, DATA and STOP.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and wraps at bit boundaries.
- Bit index: 3 bits, 0..7.
- Simultaneous write and pop: `fifo_count` is unchanged. Read and write pointers wrap modulo `FIFO_DEPTH`.
- Reset mid-frame: the frame is truncated, `o_tx` goes high immediately (asynchronous), and the FIFO contents are discarded.

## Timing
- A write sampled at edge N gives `fifo_count`=1 after edge N.
- The pop happens at edge N+1, and `o_tx` falls after edge N+1. Latency from strobe to start bit is 2 edges.
- Each bit lasts exactly `CLKS_PER_BIT` cycles. One frame is 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames: the next start bit immediately follows the stop bit.
- `o_tx` is driven directly from a flop and has no combinational path from the inputs.
- `fifo_full`, `fifo_count` and `overflow` are registered.

## Structure
- Shared package `uart_pkg`: FSM state encoding (IDLE, START, DATA, STOP), `UART_DATA_BITS`=8, and the idle line level constant. The UART receiver uses the same package.
- Sub-module `sync_fifo`: parameterized width and depth, with ports `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`, `count`.
  - First-word-fall-through: `rd_data` is valid whenever `empty`=0.
- The top-level `uart_tx_buffered` contains the FSM, baud counter, shift register and overflow flag.

## Test plan
The bench uses `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=16.
- Reset then idle for 100 cycles: `o_tx`=1, `busy`=0, `fifo_count`=0 throughout.
- Single byte 0x55 strobed at edge N: `o_tx` falls after N+1 and then carries the bits 0,1,0,1,0,1,0,1,0,1, each exactly 4 cycles. `busy` is high for 40 cycles.
- Bytes 0x41, 0x42, 0x43 strobed on three consecutive cycles: 3 frames with no idle gap, decoded as 0x41, 0x42, 0x43. `busy` is continuous for 120 cycles, and `fifo_count` peaks at 2.
- 18 strobes on consecutive cycles with bytes 0x00..0x11:
  - `fifo_full`=1 after the 17th write.
  - `overflow`=1 after the 18th write.
  - 0x00..0x10 are transmitted in order and 0x11 never appears.
- Write on the exact cycle the STOP→START pop occurs while the FIFO is full: the write is accepted, `fifo_count` stays 16, and `overflow` stays 0.
- 0xA5 in flight with `reset` asserted mid-DATA at bit 3: `o_tx`=1 and `busy`=0 immediately. After release, a new byte 0x3C transmits a correct, complete frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_BIT_IDX_W  = $clog2(UART_DATA_BITS);
    localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rd_data is valid whenever empty is low.
// Pointers wrap modulo DEPTH, so DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    // A write into a full FIFO is legal only when a read frees a slot in the same cycle.
    assign do_rd = rd_en && (count_q != '0);
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    // With a power-of-two depth, the count MSB is set only at exactly DEPTH entries.
    assign full    = count_q[AW];
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a FIFO absorbs CPU write bursts, the FSM serializes
// bytes LSB first at a fixed baud divisor and chains frames without an idle gap.
module uart_tx_buffered #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   tx_Data,
    input  logic                         tx_DataValid,
    output logic                         o_tx,
    output logic                         busy,
    output logic                         fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow
);

    import uart_pkg::*;

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    uart_state_e                state_q, state_d;
    logic [BAUD_W-1:0]          baud_q, baud_d;
    logic [UART_BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
    logic                       o_tx_q, o_tx_d;
    logic                       overflow_q;
    logic                       baud_last;
    logic                       pop;
    logic                       wr_en;
    logic                       fifo_empty;
    logic [7:0]                 fifo_rd_data;

    assign wr_en = tx_DataValid && (!fifo_full || pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (tx_Data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == UART_BIT_IDX_W'(UART_DATA_BITS - 1)) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + UART_BIT_IDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is precomputed from next state so o_tx comes straight off a flop.
        case (state_d)
            StStart: o_tx_d = ~UART_IDLE_LEVEL;
            StData:  o_tx_d = shift_d[bit_idx_d];
            default: o_tx_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            o_tx_q     <= UART_IDLE_LEVEL;
            overflow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            o_tx_q    <= o_tx_d;
            if (tx_DataValid && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign o_tx     = o_tx_q;
    assign busy     = (state_q != StIdle);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: directed scenarios plus a random burst,
// with a line-level receiver model decoding frames from o_tx.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_Data;
    logic       tx_DataValid;
    logic       o_tx;
    logic       busy;
    logic       fifo_full;
    logic [4:0] fifo_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int peak   = 0;

    logic [8:0] rx_q[$];   // {stop_bit_ok, byte} as decoded from the line
    logic [7:0] exp_q[$];  // bytes the model expects to see transmitted

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_Data      (tx_Data),
        .tx_DataValid (tx_DataValid),
        .o_tx         (o_tx),
        .busy         (busy),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    // Line receiver: detects a falling edge, then samples each bit at its centre.
    initial begin
        logic       prev;
        logic [7:0] b;
        logic       stop_ok;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && o_tx === 1'b0 && reset === 1'b0) begin
                repeat (CPB + CPB / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    b[k] = o_tx;
                    if (k < 7) repeat (CPB) @(negedge clk);
                end
                repeat (CPB) @(negedge clk);
                stop_ok = (o_tx === 1'b1);
                rx_q.push_back({stop_ok, b});
                prev = o_tx;
            end else begin
                prev = o_tx;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for bit slot k of an 8N1 frame (0 = start, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic check_line(input logic [7:0] b, input int i, input string tag);
        chk($sformatf("%s o_tx[%0d]", tag, i), o_tx, frame_bit(b, i / CPB));
        chk($sformatf("%s busy[%0d]", tag, i), busy, 1'b1);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
    endtask

    // Checks frame samples from..FRAME-1; caller is already positioned at sample 'from'.
    task automatic run_frame(input logic [7:0] b, input int from, input string tag);
        for (int i = from; i < FRAME; i++) begin
            if (i != from) step();
            check_line(b, i, tag);
        end
    endtask

    task automatic chk_rx(input string tag);
        chk($sformatf("%s rx_count", tag), rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) begin
                chk($sformatf("%s rx_byte%0d", tag, i), rx_q[i], {1'b1, exp_q[i]});
            end
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        tx_DataValid = 1'b0;
        repeat (3) begin
            step();
            chk("rst o_tx", o_tx, 1'b1);
            chk("rst busy", busy, 1'b0);
            chk("rst count", fifo_count, 0);
            chk("rst full", fifo_full, 1'b0);
            chk("rst overflow", overflow, 1'b0);
        end
        reset = 1'b0;
    endtask

    initial begin
        int         exp_cnt;
        logic [7:0] b;

        reset        = 1'b1;
        tx_Data      = 8'h00;
        tx_DataValid = 1'b0;

        // Reset, then a quiet line for 100 cycles
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle o_tx", o_tx, 1'b1);
            chk("idle busy", busy, 1'b0);
            chk("idle count", fifo_count, 0);
        end

        // Single byte 0x55: start bit appears two edges after the strobe
        tx_Data = 8'h55; tx_DataValid = 1'b1;
        step();
        tx_DataValid = 1'b0;
        chk("b55 count_after_wr", fifo_count, 1);
        chk("b55 o_tx_before_start", o_tx, 1'b1);
        step();
        run_frame(8'h55, 0, "b55");
        step();
        chk("b55 busy_end", busy, 1'b0);
        chk("b55 o_tx_end", o_tx, 1'b1);
        exp_q.push_back(8'h55);
        chk_rx("b55");

        // Three back-to-back bytes
        peak = 0;
        tx_Data = 8'h41; tx_DataValid = 1'b1;
        step();
        chk("abc count_n", fifo_count, 1);
        tx_Data = 8'h42;
        step();
        chk("abc count_n1", fifo_count, 1);
        check_line(8'h41, 0, "abc0");
        tx_Data = 8'h43;
        step();
        tx_DataValid = 1'b0;
        chk("abc count_n2", fifo_count, 2);
        run_frame(8'h41, 1, "abc0");
        step();
        run_frame(8'h42, 0, "abc1");
        step();
        run_frame(8'h43, 0, "abc2");
        step();
        chk("abc busy_end", busy, 1'b0);
        chk("abc peak", peak, 2);
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
        chk_rx("abc");

        // 18 consecutive strobes: the 18th hits a full FIFO and is dropped
        do_reset();
        for (int k = 0; k < 18; k++) begin
            tx_Data = 8'(k); tx_DataValid = 1'b1;
            step();
            if (k < DEPTH + 1) exp_q.push_back(8'(k));
            // k+1 writes offered, one pop at the second edge, capped at DEPTH
            exp_cnt = (k == 0) ? 1 : ((k < DEPTH) ? k : DEPTH);
            chk($sformatf("ovf count_w%0d", k), fifo_count, exp_cnt);
            chk($sformatf("ovf full_w%0d", k), fifo_full, (exp_cnt == DEPTH));
            chk($sformatf("ovf flag_w%0d", k), overflow, (k == 17));
        end
        tx_DataValid = 1'b0;
        repeat (17 * FRAME + 10) step();
        chk("ovf flag_sticky", overflow, 1'b1);
        chk("ovf busy_end", busy, 1'b0);
        chk_rx("ovf");

        // Write into a full FIFO on the exact STOP->START pop edge
        do_reset();
        for (int k = 0; k < DEPTH + 1; k++) begin
            tx_Data = 8'h80 + 8'(k); tx_DataValid = 1'b1;
            step();
            exp_q.push_back(8'h80 + 8'(k));
        end
        tx_DataValid = 1'b0;
        chk("pop_wr count_full", fifo_count, DEPTH);
        chk("pop_wr full", fifo_full, 1'b1);
        repeat (FRAME - DEPTH) step();
        chk("pop_wr count_pre", fifo_count, DEPTH);
        chk("pop_wr o_tx_stop", o_tx, 1'b1);
        chk("pop_wr busy_stop", busy, 1'b1);
        tx_Data = 8'h91; tx_DataValid = 1'b1;
        step();
        tx_DataValid = 1'b0;
        exp_q.push_back(8'h91);
        chk("pop_wr count_post", fifo_count, DEPTH);
        chk("pop_wr overflow", overflow, 1'b0);
        chk("pop_wr o_tx_start", o_tx, 1'b0);
        repeat (18 * FRAME + 10) step();
        chk("pop_wr overflow_end", overflow, 1'b0);
        chk_rx("pop_wr");

        // Reset in the middle of data bit 3 of 0xA5, with 0x5A still queued
        do_reset();
        tx_Data = 8'hA5; tx_DataValid = 1'b1;
        step();
        tx_Data = 8'h5A;
        step();
        tx_DataValid = 1'b0;
        run_frame(8'hA5, 0, "mid");
        // run_frame above covers the full frame; re-run a fresh one for the truncation case
        step();
        run_frame(8'h5A, 0, "mid_q");
        step();
        rx_q.delete();
        tx_Data = 8'hA5; tx_DataValid = 1'b1;
        step();
        tx_Data = 8'h5A;
        step();
        tx_DataValid = 1'b0;
        for (int i = 0; i <= CPB * 4 + 1; i++) begin
            if (i != 0) step();
            check_line(8'hA5, i, "trunc");
        end
        reset = 1'b1;
        #1;
        chk("trunc o_tx_async", o_tx, 1'b1);
        chk("trunc busy_async", busy, 1'b0);
        chk("trunc count_async", fifo_count, 0);
        repeat (3) step();
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("trunc idle_o_tx", o_tx, 1'b1);
            chk("trunc idle_busy", busy, 1'b0);
        end
        rx_q.delete();
        exp_q.delete();
        tx_Data = 8'h3C; tx_DataValid = 1'b1;
        step();
        tx_DataValid = 1'b0;
        step();
        run_frame(8'h3C, 0, "after_rst");
        step();
        chk("after_rst busy_end", busy, 1'b0);
        exp_q.push_back(8'h3C);
        chk_rx("after_rst");

        // Random bytes with random gaps, never enough to fill the FIFO
        do_reset();
        for (int k = 0; k < 12; k++) begin
            b = 8'($urandom);
            tx_Data = b; tx_DataValid = 1'b1;
            step();
            tx_DataValid = 1'b0;
            exp_q.push_back(b);
            repeat ($urandom_range(0, 3)) step();
        end
        repeat (12 * FRAME + 20) step();
        chk("rand overflow", overflow, 1'b0);
        chk("rand count_end", fifo_count, 0);
        chk("rand busy_end", busy, 1'b0);
        chk_rx("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
